// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the piso_serializer block.
//   piso_state_e     - serializer FSM state encoding
//   PisoDefaultWidth - default parallel word width
//   piso_cnt_width() - bit counter width for a given word width
package piso_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StDone   = 2'd3
  } piso_state_e;

  localparam int unsigned PisoDefaultWidth = 8;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int unsigned piso_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: loadable WIDTH-bit shift register with selectable shift direction.
// Ports:
//   i_clock     - clock, all state on posedge
//   i_reset_n   - synchronous active-low reset, clears the register
//   i_load      - capture i_din (has priority over shifting)
//   i_shift_en  - shift by one position this cycle
//   i_msb_first - 1: present/shift out the MSB, 0: present/shift out the LSB
//   i_din       - parallel word to load
//   o_bit       - bit currently at the output end of the register
module piso_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic             i_msb_first,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_din;
    end else if (i_shift_en) begin
      if (i_msb_first) begin
        r_data <= {r_data[WIDTH-2:0], 1'b0};
      end else begin
        r_data <= {1'b0, r_data[WIDTH-1:1]};
      end
    end
  end

  assign o_bit = i_msb_first ? r_data[WIDTH-1] : r_data[0];

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// one bit per clock, followed by a one-cycle done pulse.
// Ports:
//   clock      - clock, all logic on posedge
//   reset_n    - synchronous active-low reset; aborts any word in flight
//   din        - parallel word from the upstream register
//   din_valid  - din holds a word to send
//   din_ready  - block accepts a word this cycle (IDLE only)
//   sout       - serial data bit, held 0 when sout_valid is 0
//   sout_valid - sout carries a real bit this cycle
//   busy       - a word is being serialized
//   done       - one-cycle pulse after the last bit of a word
// Build option: define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PisoDefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = piso_cnt_width(WIDTH);

  piso_state_e r_state;
  logic [CntW-1:0] r_cnt;
  logic r_din_ready;
  logic r_sout_valid;
  logic r_busy;
  logic r_done;
`ifdef PISO_PARITY_EN
  logic r_parity;
`endif

  logic w_load;
  logic w_shift;
  logic w_shreg_bit;

  assign w_load  = (r_state == StIdle) && din_valid;
  assign w_shift = (r_state == StShift);

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .i_clock    (clock),
    .i_reset_n  (reset_n),
    .i_load     (w_load),
    .i_shift_en (w_shift),
    .i_msb_first(MSB_FIRST),
    .i_din      (din),
    .o_bit      (w_shreg_bit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_din_ready  <= 1'b1;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (din_valid) begin
            r_state      <= StShift;
            r_cnt        <= CntW'(WIDTH);
            r_din_ready  <= 1'b0;
            r_sout_valid <= 1'b1;
            r_busy       <= 1'b1;
`ifdef PISO_PARITY_EN
            // Even parity: the extra bit makes the total count of ones even.
            r_parity     <= ^din;
`endif
          end
        end
        StShift: begin
          r_cnt <= r_cnt - CntW'(1);
          // Counter value 1 marks the last data bit on sout this cycle.
          if (r_cnt == CntW'(1)) begin
`ifdef PISO_PARITY_EN
            r_state <= StParity;
`else
            r_state      <= StDone;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        StParity: begin
          r_state      <= StDone;
          r_sout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
        end
`endif
        StDone: begin
          r_state     <= StIdle;
          r_done      <= 1'b0;
          r_din_ready <= 1'b1;
        end
        default: begin
          r_state      <= StIdle;
          r_din_ready  <= 1'b1;
          r_sout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  // sout is decoded from registered state only, so it is 0 outside valid bit slots.
  always_comb begin
    sout = 1'b0;
    if (r_state == StShift) begin
      sout = w_shreg_bit;
    end
`ifdef PISO_PARITY_EN
    if (r_state == StParity) begin
      sout = r_parity;
    end
`endif
  end

  assign din_ready  = r_din_ready;
  assign sout_valid = r_sout_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance share stimulus.
// A queue-style model predicts every output each cycle; directed literals pin key sequences.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int W = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic [7:0] din;
  logic       din_valid;

  logic rdy0, so0, sv0, bsy0, dn0;
  logic rdy1, so1, sv1, bsy1, dn1;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .sout(so0), .sout_valid(sv0), .busy(bsy0), .done(dn0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .sout(so1), .sout_valid(sv1), .busy(bsy1), .done(dn1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 sending a list of bits, 2 done pulse.
  int          m_phase[2] = '{0, 0};
  logic [15:0] m_bits[2];
  int          m_len[2]   = '{0, 0};
  int          m_pos[2]   = '{0, 0};

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_phase[i] = 0;
        m_pos[i]   = 0;
        m_len[i]   = 0;
      end else begin
        case (m_phase[i])
          0: if (din_valid) begin
            m_bits[i] = '0;
            for (int b = 0; b < W; b++) m_bits[i][b] = (i == 0) ? din[W-1-b] : din[b];
            m_bits[i][W] = ^din;
            m_len[i]   = W + P;
            m_pos[i]   = 0;
            m_phase[i] = 1;
          end
          1: begin
            m_pos[i]++;
            if (m_pos[i] == m_len[i]) m_phase[i] = 2;
          end
          default: m_phase[i] = 0;
        endcase
      end
    end
  end

  // {din_ready, sout, sout_valid, busy, done}
  function automatic logic [4:0] model_exp(input int i);
    logic s;
    s = (m_phase[i] == 1) ? m_bits[i][m_pos[i]] : 1'b0;
    return {m_phase[i] == 0, s, m_phase[i] == 1, m_phase[i] == 1, m_phase[i] == 2};
  endfunction

  always @(negedge clock) begin
    chk("cycle_msb", {27'd0, rdy0, so0, sv0, bsy0, dn0}, {27'd0, model_exp(0)});
    chk("cycle_lsb", {27'd0, rdy1, so1, sv1, bsy1, dn1}, {27'd0, model_exp(1)});
  end

  // Per-cycle captures, bit k = cycle k after the accept edge.
  logic [31:0] c_so0, c_so1, c_sv0, c_dn0, c_dn1, c_rdy0, c_bsy0, c_m0;

  task automatic start(input logic [7:0] w);
    din       = w;
    din_valid = 1'b1;
    @(negedge clock);
  endtask

  task automatic capture(input logic [7:0] w2, input int chg_at, input int drop_at,
                         input int rst_at, input int n);
    logic [4:0] m;
    c_so0 = '0; c_so1 = '0; c_sv0 = '0; c_dn0 = '0; c_dn1 = '0;
    c_rdy0 = '0; c_bsy0 = '0; c_m0 = '0;
    for (int k = 0; k < n; k++) begin
      m         = model_exp(0);
      c_m0[k]   = m[3];
      c_so0[k]  = so0;
      c_so1[k]  = so1;
      c_sv0[k]  = sv0;
      c_dn0[k]  = dn0;
      c_dn1[k]  = dn1;
      c_rdy0[k] = rdy0;
      c_bsy0[k] = bsy0;
      if (k == chg_at) din = w2;
      if (k == drop_at) din_valid = 1'b0;
      if (k == rst_at) reset_n = 1'b0;
      if (k == rst_at + 1) reset_n = 1'b1;
      @(negedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    din       = 8'hFF;
    din_valid = 1'b1;

    // Reset holds off capture even with din_valid high.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_hold_msb", {29'd0, rdy0, sv0, dn0}, 32'b100);
      chk("rst_hold_lsb", {29'd0, rdy1, sv1, dn1}, 32'b100);
    end
    din_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clock);
    chk("rst_nocapture", {30'd0, bsy0, rdy0}, 32'b01);

    // MSB-first basic word.
    start(8'b10011000);
    capture(8'h00, -10, 0, -10, 12);
    chk("t1_msb_bits", c_so0[7:0], 8'b00011001);
    chk("t1_model_bits", c_m0[7:0], 8'b00011001);
    chk("t1_lsb_bits", c_so1[7:0], 8'b10011000);
    chk("t1_valid", c_sv0[7:0], 8'hFF);
    chk("t1_done", c_dn0[11:0], 32'd1 << (8 + P));
    chk("t1_ready_back", c_rdy0[9+P], 1'b1);
    chk("t1_ready_low", c_rdy0 & ((32'd1 << (9 + P)) - 1), 32'd0);
`ifdef PISO_PARITY_EN
    chk("t1_parity", {30'd0, c_sv0[8], c_so0[8]}, 32'b11);
`endif

    // LSB-first with din changed mid-shift.
    start(8'b11111100);
    capture(8'h00, 3, 0, -10, 12);
    chk("t2_lsb_bits", c_so1[7:0], 8'b11111100);
    chk("t2_msb_bits", c_so0[7:0], 8'b00111111);
    chk("t2_done_lsb", c_dn1[11:0], 32'd1 << (8 + P));
`ifdef PISO_PARITY_EN
    chk("t2_parity", {31'd0, c_so1[8]}, 32'd0);
`endif

    // Back-to-back with din_valid held high.
    start(8'b10011110);
    capture(8'b10000001, 0, 10 + P, -10, 22 + 2 * P);
    chk("t3_first_bits", c_so0[7:0], 8'b01111001);
    chk("t3_model_first", c_m0[7:0], 8'b01111001);
    chk("t3_second_bits", (c_so0 >> (10 + P)) & 32'hFF, 8'b10000001);
    chk("t3_not_early", c_bsy0[9+P], 1'b0);
    chk("t3_accept_gap", c_bsy0[10+P], 1'b1);
    chk("t3_done", c_dn0, (32'd1 << (8 + P)) | (32'd1 << (18 + 2 * P)));
`ifdef PISO_PARITY_EN
    chk("t3_par_first", {31'd0, c_so0[8]}, 32'd1);
    chk("t3_par_second", {31'd0, c_so0[19]}, 32'd0);
`endif

    // Reset during the 4th shift cycle.
    start(8'b10011000);
    capture(8'h00, -10, 0, 3, 12);
    chk("t4_bits_pre", c_so0[3:0], 4'b1001);
    chk("t4_valid_pre", c_sv0[4:0], 5'b01111);
    chk("t4_busy_after", c_bsy0[4], 1'b0);
    chk("t4_ready_after", c_rdy0[4], 1'b1);
    chk("t4_no_done", c_dn0 | c_dn1, 32'd0);

    // Clean word after the abort.
    start(8'h81);
    capture(8'h00, -10, 0, -10, 12);
    chk("t5_msb_bits", c_so0[7:0], 8'h81);
    chk("t5_valid", c_sv0[7:0], 8'hFF);
    chk("t5_done", c_dn0[11:0], 32'd1 << (8 + P));
`ifdef PISO_PARITY_EN
    chk("t5_parity", {30'd0, c_sv0[8], c_so0[8]}, 32'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
